// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// FSM state encodings and the default operand width.
package mdu_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // Upper op bit selects the divide class.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // MULT and DIV work on two's-complement operands.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on the {upper, lower} accumulator.
// Multiply: conditional add of the multiplicand into the upper half, then
// shift the whole accumulator right (the multiplier drains out of the low end).
// Divide: shift the partial remainder left by one dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow, and shift the
// quotient bit into the low end.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0] w_add;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    // Single shift-add or shift-compare-subtract step.
    always_comb begin
        w_add    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, i_opnd};
        if (i_is_div) begin
            // Bit WIDTH of the difference is the borrow: set means restore.
            if (!w_diff[WIDTH]) begin
                o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_add, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO register pair.
// All state moves on the falling clock edge, alongside the PC and HILO.
// Handshake: start is only taken in IDLE or DONE; busy covers PREP..FIX;
// done/hilo_we pulse for the single DONE cycle; cancel drops an operation
// in flight without touching hi/lo.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [2:0]       dbg_state
);

    state_e               r_state;
    state_e               w_state_next;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_opnd;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_is_div;
    logic                 w_signed;
    logic                 w_last;
    logic [WIDTH-1:0]     w_a_abs;
    logic [WIDTH-1:0]     w_b_abs;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_prod_neg;
    logic [WIDTH-1:0]     w_quo_neg;
    logic [WIDTH-1:0]     w_rem_neg;

    assign w_is_div   = op_is_div(r_op);
    assign w_signed   = op_is_signed(r_op);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_a_abs    = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_b_abs    = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;
    assign w_prod_neg = -r_acc;
    assign w_quo_neg  = -r_acc[WIDTH-1:0];
    assign w_rem_neg  = -r_acc[2*WIDTH-1:WIDTH];

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (w_is_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_step)
    );

    // State register.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; cancel wins over everything while busy.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_next = start ? S_PREP : S_IDLE;
            S_PREP:         w_state_next = cancel ? S_IDLE : S_CALC;
            S_CALC:         w_state_next = cancel ? S_IDLE : (w_last ? S_FIX : S_CALC);
            S_FIX:          w_state_next = cancel ? S_IDLE : S_DONE;
            default:        w_state_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        hilo_we = 1'b0;
        case (r_state)
            S_PREP, S_CALC, S_FIX: busy = 1'b1;
            S_DONE: begin
                done    = 1'b1;
                hilo_we = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture, sign extraction, iteration and result fixup.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= a;
                        r_b  <= b;
                    end
                end
                S_PREP: begin
                    // Multiply iterates over b with a as the addend; divide
                    // shifts a out as the dividend with b as the divisor.
                    r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_a_abs : w_b_abs)};
                    r_opnd    <= w_is_div ? w_b_abs : w_a_abs;
                    r_neg_res <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_rem <= w_signed & r_a[WIDTH-1];
                    r_cnt     <= '0;
                end
                S_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    // A cancelled operation must leave hi/lo untouched.
                    if (!cancel) begin
                        if (w_is_div) begin
                            r_lo <= r_neg_res ? w_quo_neg : r_acc[WIDTH-1:0];
                            r_hi <= r_neg_rem ? w_rem_neg : r_acc[2*WIDTH-1:WIDTH];
                        end else begin
                            {r_hi, r_lo} <= r_neg_res ? w_prod_neg : r_acc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a table of operations with hand-computed
// HI/LO results, followed by hand-written control sequences (ignored start,
// cancel, asynchronous reset mid-operation, back-to-back issue from DONE).
// The DUT moves on negedge; the bench drives and samples on posedge.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 2;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  // clock / reset
  logic clk = 1'b1;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, hilo_we;
  logic [W-1:0] hi, lo;
  logic [2:0]   dbg_state;

  int total = 0;
  int bad = 0;

  vec_t vecs[13];

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hilo_we   (hilo_we),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request before a falling edge (edge 0), then drop start.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    @(posedge clk);
    start = 1'b0;
  endtask

  // Count falling edges until done is seen, bounded.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      @(posedge clk);
    end
  endtask

  task automatic run_vec(input int i);
    int n;
    launch(vecs[i].op, vecs[i].a, vecs[i].b);
    check($sformatf("v%0d_busy", i), 64'(busy), 64'(1));
    wait_done(0, n);
    check($sformatf("v%0d_latency", i), 64'(n), 64'(LAT));
    check($sformatf("v%0d_hilo_we", i), 64'(hilo_we), 64'(1));
    check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
    check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
    @(negedge clk);
    @(posedge clk);
    check($sformatf("v%0d_done_drop", i), 64'(done), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;

    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[5]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6]  = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0001};
    vecs[7]  = '{OP_DIV,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[8]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[10] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[12] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

    // reset state
    #2;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    @(posedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i);

    // start at edge 5 while busy is ignored: 3*3 completes on time
    launch(OP_MULTU, 32'd3, 32'd3);
    repeat (4) begin
      @(negedge clk);
      @(posedge clk);
    end
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    @(posedge clk);
    start = 1'b0;
    wait_done(5, n);
    check("ign_latency", 64'(n), 64'(LAT));
    check("ign_hi", 64'(hi), 64'(0));
    check("ign_lo", 64'(lo), 64'(9));
    @(negedge clk);
    @(posedge clk);

    // cancel sampled at edge 11: busy drops, no done, hi/lo keep 0/9
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (10) begin
      @(negedge clk);
      @(posedge clk);
    end
    cancel = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    cancel = 1'b0;
    start = 1'b0;
    check("cxl_busy", 64'(busy), 64'(0));
    check("cxl_state", 64'(dbg_state), 64'(S_IDLE));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      @(posedge clk);
      seen = seen | done | busy;
    end
    check("cxl_no_done", 64'(seen), 64'(0));
    check("cxl_hi", 64'(hi), 64'(0));
    check("cxl_lo", 64'(lo), 64'(9));

    // asynchronous reset in the middle of an operation
    launch(OP_MULTU, 32'd5, 32'd5);
    repeat (20) begin
      @(negedge clk);
      @(posedge clk);
    end
    check("pre_rst_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_we", 64'(hilo_we), 64'(0));
    check("arst_hi", 64'(hi), 64'(0));
    check("arst_lo", 64'(lo), 64'(0));
    check("arst_state", 64'(dbg_state), 64'(S_IDLE));
    @(posedge clk);
    rst_n = 1'b1;

    // back-to-back: issue from DONE goes straight to PREP
    launch(OP_MULTU, 32'd6, 32'd7);
    wait_done(0, n);
    check("b2b0_latency", 64'(n), 64'(LAT));
    check("b2b0_lo", 64'(lo), 64'(42));
    start = 1'b1; op = OP_DIVU; a = 32'd42; b = 32'd5;
    @(negedge clk);
    @(posedge clk);
    start = 1'b0;
    check("b2b1_busy", 64'(busy), 64'(1));
    wait_done(0, n);
    check("b2b1_latency", 64'(n), 64'(LAT));
    check("b2b1_hi", 64'(hi), 64'(2));
    check("b2b1_lo", 64'(lo), 64'(8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
